// File: rtl/score_seg_display.sv
// Score display: clamps a binary score, converts it to BCD with a sequential double-dabble
// and scans four active-low 7-segment digits. Define SCORE_LZ_BLANK_EN to blank leading zeros.
module score_seg_display #(
    parameter int SCAN_BITS = 17,
    parameter int MAX_SCORE = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score_in,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    localparam logic [15:0] MAX_VAL = 16'(MAX_SCORE);

    state_t                 state;
    logic [31:0]            shreg;
    logic [3:0]             iter;
    logic                   clamp_q;
    logic                   pend_valid;
    logic [15:0]            pend_val;
    logic [15:0]            digits;
    logic [SCAN_BITS-1:0]   scan;
    logic [15:0]            start_val;
    logic [1:0]             sel;
    logic [3:0]             nib;
    logic                   blank;

    // Upper half holds the BCD nibbles, lower half the binary value being shifted in.
    function automatic logic [31:0] dd_step(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (t[16+4*i +: 4] >= 4'd5)
                t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[30:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'h7F;
        endcase
    endfunction

    // A fresh load in IDLE is newer than anything pending, so it wins.
    always_comb begin
        start_val = load ? score_in : pend_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            iter       <= '0;
            clamp_q    <= 1'b0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            digits     <= '0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (load && state != IDLE) begin
                pend_valid <= 1'b1;
                pend_val   <= score_in;
            end
            case (state)
                IDLE: begin
                    if (load || pend_valid) begin
                        shreg      <= {16'h0000, (start_val > MAX_VAL) ? MAX_VAL : start_val};
                        clamp_q    <= start_val > MAX_VAL;
                        iter       <= '0;
                        busy       <= 1'b1;
                        pend_valid <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    shreg <= dd_step(shreg);
                    iter  <= iter + 4'd1;
                    if (iter == 4'd15)
                        state <= COMMIT;
                end
                COMMIT: begin
                    digits <= shreg[31:16];
                    ovf    <= clamp_q;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sel = scan[SCAN_BITS-1 -: 2];
        nib = digits[4*sel +: 4];
`ifdef SCORE_LZ_BLANK_EN
        case (sel)
            2'd1:    blank = digits[15:4] == 12'h000;
            2'd2:    blank = digits[15:8] == 8'h00;
            2'd3:    blank = digits[15:12] == 4'h0;
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan <= '0;
            an   <= 4'b1110;
            seg  <= 7'b1000000;
        end else begin
            scan <= scan + 1'b1;
            case (sel)
                2'd0:    an <= 4'b1110;
                2'd1:    an <= 4'b1101;
                2'd2:    an <= 4'b1011;
                default: an <= 4'b0111;
            endcase
            seg <= blank ? 7'h7F : decode(nib);
        end
    end

endmodule

// File: tb/tb_score_seg_display.sv
// Scoreboard bench for score_seg_display; short scan period keeps full digit sweeps cheap.
module tb_score_seg_display;

    localparam int SB  = 6;      // digit period 16 clocks
    localparam int MAX = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] score_in;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    score_seg_display #(.SCAN_BITS(SB), .MAX_SCORE(MAX)) dut (
        .clk(clk), .rst(rst), .score_in(score_in), .load(load),
        .busy(busy), .ovf(ovf), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = (v > MAX) ? MAX : v;
        return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] bcd, input int pos);
`ifdef SCORE_LZ_BLANK_EN
        if (pos > 0 && (bcd >> (4 * pos)) == 16'h0000) return 7'h7F;
`endif
        return seg_of(bcd[4*pos +: 4]);
    endfunction

    // Called on a negedge; load is sampled by the next posedge; returns on the following negedge.
    task automatic do_load(input int v, input bit replace);
        exp_t e;
        score_in = 16'(v);
        load     = 1'b1;
        if (replace && sb.size() > 0) void'(sb.pop_back());
        e.bcd = to_bcd(v);
        e.ovf = (v > MAX);
        sb.push_back(e);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        bit seen;
        seen = busy;
        while (!(seen && !busy) && n < 400) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            n++;
        end
        tests++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s_done: busy never completed, busy=%b required falling busy", name, busy);
        end
    endtask

    task automatic check_display(input string name, input int window);
        exp_t  e;
        int    bad = 0;
        int    pos;
        string msg = "";
        @(negedge clk);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < window; k++) begin
            case (an)
                4'b1110: pos = 0;
                4'b1101: pos = 1;
                4'b1011: pos = 2;
                4'b0111: pos = 3;
                default: pos = -1;
            endcase
            if (pos < 0 || seg !== exp_seg(e.bcd, pos) || ovf !== e.ovf) begin
                if (bad == 0)
                    msg = $sformatf("an=%b seg=%b ovf=%b, required seg=%b ovf=%b for digits %h",
                                    an, seg, ovf, (pos < 0) ? 7'h7F : exp_seg(e.bcd, pos), e.ovf, e.bcd);
                bad++;
            end
            @(negedge clk);
        end
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d bad samples, first: %s", name, bad, msg);
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        logic [3:0] want;
        rst = 1'b1; load = 1'b0; score_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({an, seg, busy, ovf} !== {4'b1110, 7'b1000000, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: an=%b seg=%b busy=%b ovf=%b required 1110 1000000 0 0", an, seg, busy, ovf);
        end
        for (int j = 1; j <= 140; j++) begin
            @(negedge clk);
            want = ~(4'b0001 << (((j - 1) >> 4) & 3));
            if (an !== want || seg !== 7'b1000000 || busy !== 1'b0) begin
                if (bad == 0)
                    $display("FAIL reset_scan: cycle %0d an=%b seg=%b busy=%b required an=%b seg=1000000 busy=0",
                             j, an, seg, busy, want);
                bad++;
            end
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    task automatic test_convert;
        int cnt = 0;
        do_load(1234, 1'b0);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        tests++;
        if (cnt !== 17) begin
            fails++;
            $display("FAIL busy_len: busy high %0d cycles, required 17", cnt);
        end
        check_display("show_1234", 70);
    endtask

    task automatic test_clamp;
        do_load(12000, 1'b0);
        wait_done("clamp");
        check_display("clamp_9999", 70);
        do_load(7, 1'b0);
        wait_done("seven");
        check_display("show_7", 70);
    endtask

    task automatic test_back_to_back;
        do_load(5, 1'b0);
        repeat (2) @(negedge clk);
        do_load(42, 1'b0);
        repeat (2) @(negedge clk);
        do_load(99, 1'b1);
        wait_done("b2b_first");
        check_display("b2b_5", 15);
        wait_done("b2b_second");
        check_display("b2b_99", 70);
    endtask

    task automatic test_abort;
        exp_t e;
        do_load(8765, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        e.bcd = 16'h0000;
        e.ovf = 1'b0;
        sb.push_back(e);
        tests++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL abort_flags: busy=%b ovf=%b required 0 0", busy, ovf);
        end
        check_display("abort_zero", 70);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_lz;
        do_load(0, 1'b0);
        wait_done("lz_zero");
        check_display("show_0", 70);
        do_load(100, 1'b0);
        wait_done("lz_100");
        check_display("show_100", 70);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_clamp();
        test_back_to_back();
        test_abort();
        test_lz();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
